// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg -- shared types for the register/ALU block.
//   op_t    : opcode encoding (3-bit payload of req_op)
//   state_t : control FSM states
//   NUM_OPS : number of legal opcodes; any req_op >= NUM_OPS is illegal
package reg_alu_pkg;

  localparam int NUM_OPS = 8;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_SHR   = 3'd2,
    OP_SHL   = 3'd3,
    OP_INV   = 3'd4,
    OP_READ  = 3'd5,
    OP_ACC   = 3'd6,
    OP_XOR   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/reg_alu_if.sv
// reg_alu_if -- request/response bus of reg_alu_file.
//   req_* : valid/ready request channel (op, addr, data)
//   rsp_* : valid/ready response channel (data, addr echo, err, ovf)
//   master: request driver / response consumer side
//   slave : reg_alu_file side
interface reg_alu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OP_W   = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              rsp_ovf;

  modport master (
    output req_valid, req_op, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, rsp_ovf
  );
endinterface

// File: rtl/reg_alu_exec.sv
// reg_alu_exec -- combinational single-operand ALU.
//   op  : request opcode (OP_W bits)
//   x   : current register entry
//   d   : request operand
//   res : result (written back and/or returned)
//   we  : result must be written to the entry
//   ovf : SHL lost its MSB / ACC carried out
//   err : opcode outside the legal range
// Optional: REG_ALU_SAT_EN makes ACC saturate and SHL of a set MSB
// yield all-ones (ovf still reported).
module reg_alu_exec
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] res,
  output logic              we,
  output logic              ovf,
  output logic              err
);
  op_t             op_e;
  logic [DATA_W:0] sum;

  assign op_e = op_t'(op[2:0]);
  assign err  = (op >= OP_W'(NUM_OPS));
  assign sum  = {1'b0, x} + {1'b0, d};

  always_comb begin
    res = '0;
    we  = 1'b0;
    ovf = 1'b0;
    case (op_e)
      OP_NOP:   res = '0;
      OP_WRITE: begin res = d; we = 1'b1; end
      OP_SHR:   begin res = d >> 1; we = 1'b1; end
      OP_SHL: begin
        res = d << 1;
        we  = 1'b1;
        ovf = d[DATA_W-1];
`ifdef REG_ALU_SAT_EN
        if (d[DATA_W-1]) res = '1;
`endif
      end
      OP_INV:   begin res = ~d; we = 1'b1; end
      OP_READ:  res = x;
      OP_ACC: begin
        res = sum[DATA_W-1:0];
        we  = 1'b1;
        ovf = sum[DATA_W];
`ifdef REG_ALU_SAT_EN
        if (sum[DATA_W]) res = '1;
`endif
      end
      OP_XOR:   begin res = x ^ d; we = 1'b1; end
      default:  res = '0;
    endcase
  end
endmodule

// File: rtl/reg_alu_file.sv
// reg_alu_file -- parametrised register file with built-in ALU.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears FSM, response regs, entries)
//   bus : reg_alu_if.slave request/response channels
// One outstanding request: IDLE (accept) -> EXEC (compute/write) -> RESP
// (hold response until rsp_ready). Accept at edge N gives rsp_valid high
// after edge N+1, i.e. seen by the consumer at edge N+2.
// Optional: REG_ALU_SAT_EN (see reg_alu_exec).
module reg_alu_file
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  parameter int OP_W   = 8
) (
  input logic     clk,
  input logic     rst,
  reg_alu_if.slave bus
);
  state_t state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;

  logic [DATA_W-1:0] rsp_data_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic              rsp_err_q;
  logic              rsp_ovf_q;

  logic [DATA_W-1:0] x, res;
  logic              addr_ok, we, ovf, op_err, err;

  // Entry read by match loop: handles non-power-of-two DEPTH and flags
  // out-of-range addresses without indexing past the array.
  always_comb begin
    x       = '0;
    addr_ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        x       = regs_q[i];
        addr_ok = 1'b1;
      end
    end
  end

  reg_alu_exec #(.DATA_W(DATA_W), .OP_W(OP_W)) u_exec (
    .op  (op_q),
    .x   (x),
    .d   (data_q),
    .res (res),
    .we  (we),
    .ovf (ovf),
    .err (op_err)
  );

  assign err = op_err | ~addr_ok;

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      regs_q     <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.req_valid) begin
        op_q   <= bus.req_op;
        addr_q <= bus.req_addr;
        data_q <= bus.req_data;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= err ? '0 : res;
        rsp_addr_q <= addr_q;
        rsp_err_q  <= err;
        rsp_ovf_q  <= ovf & ~err;
        for (int i = 0; i < DEPTH; i++) begin
          if (we && !err && addr_q == ADDR_W'(i)) regs_q[i] <= res;
        end
      end
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_addr = rsp_addr_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.rsp_ovf  = rsp_ovf_q;
endmodule
